cceip_axi_mem_responder: RTL and testbench

//  AXI4 slave (responder) backed by an internal single-port word memory; serves INCR bursts from the

---
 rtl/cceip_axi_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_cceip_axi_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cceip_axi_mem_responder.sv
// AXI4 INCR-burst responder over an internal word memory; one read or write burst in flight.
// Optional: define CCEIP_MEM_RESP_SLVERR_EN to range-check every beat and answer SLVERR outside it.
module cceip_axi_mem_responder #(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       DEPTH     = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                ap_clk,
   input  logic                areset,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [7:0]          s_awlen,
   input  logic                s_wvalid,
   output logic                s_wready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   output logic                s_bvalid,
   input  logic                s_bready,
   output logic [1:0]          s_bresp,
   input  logic                s_arvalid,
   output logic                s_arready,
   input  logic [ADDR_W-1:0]   s_araddr,
   input  logic [7:0]          s_arlen,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                err_wlast
);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;
`ifdef CCEIP_MEM_RESP_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrData, StWrResp} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   // Word offsets from BASE_ADDR kept at full width so the range check sees no wrap.
   logic [ADDR_W-1:0] rd_word, wr_word, rd_word_nxt, rd_sel_word;
   logic [7:0]        rd_len, rd_beat, wr_len, wr_beat;
   logic              wr_err, last_grant_wr;
   logic              grant_wr, grant_rd, mem_we;
   logic [DATA_W-1:0] rd_sel_data;
   logic [1:0]        rd_sel_resp;

   function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] diff;
      diff = addr - BASE_ADDR;
      return diff >> 3;
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] word);
      return !SLVERR_EN || (word < ADDR_W'(DEPTH));
   endfunction

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state == StIdle) begin
         if (s_awvalid && s_arvalid) begin
            grant_wr = !last_grant_wr;
            grant_rd = last_grant_wr;
         end else begin
            grant_wr = s_awvalid;
            grant_rd = s_arvalid;
         end
      end
   end

   assign s_awready = grant_wr;
   assign s_arready = grant_rd;

   assign rd_word_nxt = rd_word + ADDR_W'(1);
   assign rd_sel_word = (state == StRdAddr) ? rd_word : rd_word_nxt;
   assign rd_sel_data = in_range(rd_sel_word) ? mem[rd_sel_word[IDX_W-1:0]] : '0;
   assign rd_sel_resp = in_range(rd_sel_word) ? RespOkay : RespSlverr;

   assign mem_we = s_wvalid && s_wready && in_range(wr_word);

   always_ff @(posedge ap_clk) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (s_wstrb[i]) mem[wr_word[IDX_W-1:0]][8*i +: 8] <= s_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state         <= StIdle;
         last_grant_wr <= 1'b0;
         s_wready      <= 1'b0;
         s_bvalid      <= 1'b0;
         s_bresp       <= RespOkay;
         s_rvalid      <= 1'b0;
         s_rdata       <= '0;
         s_rresp       <= RespOkay;
         s_rlast       <= 1'b0;
         err_wlast     <= 1'b0;
         rd_word       <= '0;
         wr_word       <= '0;
         rd_len        <= '0;
         rd_beat       <= '0;
         wr_len        <= '0;
         wr_beat       <= '0;
         wr_err        <= 1'b0;
      end else begin
         if (state == StIdle && s_awvalid && s_arvalid) last_grant_wr <= !last_grant_wr;
         unique case (state)
            StIdle: begin
               if (grant_wr) begin
                  wr_word  <= word_of(s_awaddr);
                  wr_len   <= s_awlen;
                  wr_beat  <= '0;
                  wr_err   <= 1'b0;
                  s_wready <= 1'b1;
                  state    <= StWrData;
               end else if (grant_rd) begin
                  rd_word <= word_of(s_araddr);
                  rd_len  <= s_arlen;
                  rd_beat <= '0;
                  state   <= StRdAddr;
               end
            end
            StRdAddr: begin
               s_rvalid <= 1'b1;
               s_rdata  <= rd_sel_data;
               s_rresp  <= rd_sel_resp;
               s_rlast  <= (rd_len == 8'd0);
               state    <= StRdData;
            end
            StRdData: begin
               if (s_rready) begin
                  if (s_rlast) begin
                     s_rvalid <= 1'b0;
                     s_rlast  <= 1'b0;
                     s_rresp  <= RespOkay;
                     state    <= StIdle;
                  end else begin
                     rd_word <= rd_word_nxt;
                     rd_beat <= rd_beat + 8'd1;
                     s_rdata <= rd_sel_data;
                     s_rresp <= rd_sel_resp;
                     s_rlast <= (rd_beat + 8'd1 == rd_len);
                  end
               end
            end
            StWrData: begin
               if (s_wvalid) begin
                  // The beat count ends the burst; wlast is only audited.
                  if (s_wlast != (wr_beat == wr_len)) err_wlast <= 1'b1;
                  if (wr_beat == wr_len) begin
                     s_wready <= 1'b0;
                     s_bvalid <= 1'b1;
                     s_bresp  <= (wr_err || !in_range(wr_word)) ? RespSlverr : RespOkay;
                     state    <= StWrResp;
                  end else begin
                     wr_beat <= wr_beat + 8'd1;
                     wr_word <= wr_word + ADDR_W'(1);
                     if (!in_range(wr_word)) wr_err <= 1'b1;
                  end
               end
            end
            StWrResp: begin
               if (s_bready) begin
                  s_bvalid <= 1'b0;
                  s_bresp  <= RespOkay;
                  state    <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cceip_axi_mem_responder.sv
// Directed bench for cceip_axi_mem_responder: single-beat vector table plus burst,
// arbitration, stall, wlast-error, wrap and mid-burst reset sequences.
module tb_cceip_axi_mem_responder;
`ifdef CCEIP_MEM_RESP_SLVERR_EN
   localparam bit SLVERR = 1'b1;
`else
   localparam bit SLVERR = 1'b0;
`endif

   logic        ap_clk = 1'b0;
   logic        areset;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, err_wlast;
   logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [7:0]  s_awlen, s_arlen, s_wstrb;
   logic [1:0]  s_bresp, s_rresp;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] got_data [256];
   logic [1:0]  got_resp [256];
   logic        got_last [256];

   typedef struct {
      logic [63:0] wr_addr;
      logic [63:0] rd_addr;
      logic [63:0] prefill;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [5];

   always #5 ap_clk = ~ap_clk;

   cceip_axi_mem_responder dut (
      .ap_clk    (ap_clk),
      .areset    (areset),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_awaddr  (s_awaddr),
      .s_awlen   (s_awlen),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wlast   (s_wlast),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_bresp   (s_bresp),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rlast   (s_rlast),
      .err_wlast (err_wlast)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_wlast = 1'b0;
      s_bready = 1'b1; s_rready = 1'b1;
      tick();
      tick();
      areset = 1'b0;
   endtask

   task automatic send_aw(input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
      #1;
      while (!s_awready && n < 20) begin
         tick();
         n++;
      end
      check("awready", s_awready, 1);
      tick();
      s_awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
      #1;
      while (!s_arready && n < 20) begin
         tick();
         n++;
      end
      check("arready", s_arready, 1);
      tick();
      s_arvalid = 1'b0;
   endtask

   // Beat i carries base+i; wlast is raised on beat wlast_at. Checks bvalid one cycle after last beat.
   task automatic send_w(input logic [7:0] len, input logic [63:0] base, input logic [7:0] strb,
                         input int wlast_at, input logic [1:0] exp_bresp);
      for (int i = 0; i <= int'(len); i++) begin
         s_wdata = base + 64'(i); s_wstrb = strb; s_wlast = (i == wlast_at); s_wvalid = 1'b1;
         check("wready", s_wready, 1);
         tick();
         check("bvalid_timing", s_bvalid, (i == int'(len)) ? 64'd1 : 64'd0);
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("bresp", s_bresp, exp_bresp);
      tick();
      check("bvalid_clear", s_bvalid, 0);
   endtask

   // Reads with rready held high; captures each beat and checks the 2-cycle first-beat latency.
   task automatic do_read(input logic [63:0] addr, input logic [7:0] len);
      send_ar(addr, len);
      check("rvalid_lat", s_rvalid, 0);
      tick();
      for (int i = 0; i <= int'(len); i++) begin
         check("rvalid_beat", s_rvalid, 1);
         got_data[i] = s_rdata; got_resp[i] = s_rresp; got_last[i] = s_rlast;
         tick();
      end
      check("rvalid_end", s_rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{64'h100, 64'h100, 64'h0, 64'hDEADBEEF_01234567, 8'hFF, 64'hDEADBEEF_01234567};
      vecs[1] = '{64'h200, 64'h200, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'h0F, 64'hFFFFFFFF_00000000};
      vecs[2] = '{64'h208, 64'h208, 64'h0, 64'h11223344_55667788, 8'hF0, 64'h11223344_00000000};
      vecs[3] = '{64'h213, 64'h210, 64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555555, 8'h81,
                  64'h55AAAAAA_AAAAAA55};
      vecs[4] = '{64'h7FF8, 64'h7FF8, 64'h0, 64'hCAFEF00D_12345678, 8'hFF, 64'hCAFEF00D_12345678};
      s_awaddr = '0; s_awlen = '0; s_araddr = '0; s_arlen = '0; s_wdata = '0; s_wstrb = '0;

      // Reset state
      do_reset();
      check("rst_awready", s_awready, 0);
      check("rst_arready", s_arready, 0);
      check("rst_wready", s_wready, 0);
      check("rst_bvalid", s_bvalid, 0);
      check("rst_bresp", s_bresp, 0);
      check("rst_rvalid", s_rvalid, 0);
      check("rst_rdata", s_rdata, 0);
      check("rst_rresp", s_rresp, 0);
      check("rst_rlast", s_rlast, 0);
      check("rst_err_wlast", err_wlast, 0);

      // Single-beat vectors: prefill, strobed write, readback
      for (int v = 0; v < 5; v++) begin
         send_aw(vecs[v].rd_addr, 8'd0);
         send_w(8'd0, vecs[v].prefill, 8'hFF, 0, 2'b00);
         send_aw(vecs[v].wr_addr, 8'd0);
         send_w(8'd0, vecs[v].data, vecs[v].strb, 0, 2'b00);
         do_read(vecs[v].rd_addr, 8'd0);
         check("vec_rdata", got_data[0], vecs[v].exp);
         check("vec_rlast", got_last[0], 1);
         check("vec_rresp", got_resp[0], 0);
      end

      // 8-beat burst write/read
      send_aw(64'h0, 8'd7);
      send_w(8'd7, 64'h0, 8'hFF, 7, 2'b00);
      check("burst_err_wlast", err_wlast, 0);
      do_read(64'h0, 8'd7);
      for (int i = 0; i < 8; i++) begin
         check("burst_rdata", got_data[i], 64'(i));
         check("burst_rlast", got_last[i], (i == 7) ? 64'd1 : 64'd0);
         check("burst_rresp", got_resp[i], 0);
      end

      // Arbitration from reset: write first, then read on the next contended pair
      do_reset();
      s_awaddr = 64'h300; s_awlen = 8'd0; s_awvalid = 1'b1;
      s_araddr = 64'h0;   s_arlen = 8'd1; s_arvalid = 1'b1;
      #1;
      check("arb1_awready", s_awready, 1);
      check("arb1_arready", s_arready, 0);
      tick();
      s_awvalid = 1'b0;
      check("arb1_arready_busy", s_arready, 0);
      send_w(8'd0, 64'h3333, 8'hFF, 0, 2'b00);
      check("arb1_ar_after", s_arready, 1);
      tick();
      s_arvalid = 1'b0;
      check("stall_lat", s_rvalid, 0);
      tick();
      check("stall_b0_data", s_rdata, 64'd0);
      check("stall_b0_last", s_rlast, 0);
      tick();
      check("stall_b1_data", s_rdata, 64'd1);
      s_rready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("stall_rvalid", s_rvalid, 1);
         check("stall_rdata", s_rdata, 64'd1);
         check("stall_rlast", s_rlast, 1);
      end
      s_rready = 1'b1;
      tick();
      check("stall_done", s_rvalid, 0);

      s_awaddr = 64'h308; s_awlen = 8'd0; s_awvalid = 1'b1;
      s_araddr = 64'h300; s_arlen = 8'd0; s_arvalid = 1'b1;
      #1;
      check("arb2_arready", s_arready, 1);
      check("arb2_awready", s_awready, 0);
      tick();
      s_arvalid = 1'b0;
      tick();
      check("arb2_rdata", s_rdata, 64'h3333);
      check("arb2_rlast", s_rlast, 1);
      tick();
      check("arb2_rvalid_end", s_rvalid, 0);
      check("arb2_aw_after", s_awready, 1);
      tick();
      s_awvalid = 1'b0;
      send_w(8'd0, 64'h4444, 8'hFF, 0, 2'b00);

      // Early wlast: sticky error, burst still runs its full 4 beats
      send_aw(64'h400, 8'd3);
      send_w(8'd3, 64'h40, 8'hFF, 2, 2'b00);
      check("wlast_err", err_wlast, 1);
      do_read(64'h400, 8'd3);
      for (int i = 0; i < 4; i++) check("wlast_rdata", got_data[i], 64'h40 + 64'(i));

      // Top-of-memory burst: wraps to word 0, or SLVERR when range checking is built in
      send_aw(64'h7FF8, 8'd1);
      send_w(8'd1, 64'h77770000, 8'hFF, 1, SLVERR ? 2'b10 : 2'b00);
      do_read(64'h7FF8, 8'd1);
      check("wrap_b0_data", got_data[0], 64'h77770000);
      check("wrap_b0_resp", got_resp[0], 0);
      check("wrap_b1_data", got_data[1], SLVERR ? 64'h0 : 64'h77770001);
      check("wrap_b1_resp", got_resp[1], SLVERR ? 64'd2 : 64'd0);
      check("wrap_b1_last", got_last[1], 1);
      do_read(64'h0, 8'd0);
      check("wrap_word0", got_data[0], SLVERR ? 64'h0 : 64'h77770001);
      check("wrap_err_sticky", err_wlast, 1);

      // Reset during a stalled read burst
      s_rready = 1'b0;
      send_ar(64'h0, 8'd7);
      tick();
      check("midrst_rvalid_pre", s_rvalid, 1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      s_rready = 1'b1;
      check("midrst_rvalid", s_rvalid, 0);
      check("midrst_rdata", s_rdata, 0);
      check("midrst_err_wlast", err_wlast, 0);
      do_read(64'h100, 8'd0);
      check("midrst_mem_kept", got_data[0], 64'hDEADBEEF_01234567);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
